imem_loader: RTL and testbench

Boot-time program loader for the 8-bit RISC core: it is the write side of the instruction memory. It receives a byte stream over a valid/ready handshake, assembles 16-bit instruction words, and writes them sequentially into instruction memory starting at address 0. It holds the core in reset until a load completes successfully, then releases it.

---
 rtl/imem_loader_if.sv | 19 +
 rtl/imem_loader.sv | 185 ++++++++++++++++++
 tb/tb_imem_loader.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream handshake between a boot source and the instruction-memory loader.
// The master drives bytes and the slave (imem_loader) accepts them.
interface imem_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: turns an A5/N/data[/checksum] byte frame into 16-bit instruction-memory writes
// and holds the core in reset until a load completes. Optional feature macro: IMEM_LOADER_CHECKSUM_EN.
module imem_loader (
  input  logic              clk,
  input  logic              reset,
  imem_loader_if.slave      s_in,
  output logic              o_wr_en,
  output logic [7:0]        o_wr_addr,
  output logic [15:0]       o_wr_data,
  output logic              o_cpu_reset_n,
  output logic              o_done,
  output logic              o_error
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_HI    = 3'd2,
    S_LO    = 3'd3,
    S_WRITE = 3'd4,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CSUM  = 3'd5,
`endif
    S_DONE  = 3'd6,
    S_ERR   = 3'd7
  } state_t;

  localparam logic [7:0] HEADER = 8'hA5;

  state_t      r_state;
  state_t      w_next;
  logic        w_in_ready;
  logic        w_accept;
  logic        w_is_hdr;
  logic [8:0]  r_words;
  logic [7:0]  r_wr_addr;
  logic [15:0] r_wr_data;
  logic        r_wr_en;
  logic        r_cpu_reset_n;
  logic        r_done;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  r_csum;
  logic        r_error;
`endif

  assign w_in_ready = (r_state != S_WRITE);
  assign w_accept   = s_in.in_valid & w_in_ready;
  assign w_is_hdr   = (s_in.in_data == HEADER);

  assign s_in.in_ready = w_in_ready;
  assign o_wr_en       = r_wr_en;
  assign o_wr_addr     = r_wr_addr;
  assign o_wr_data     = r_wr_data;
  assign o_cpu_reset_n = r_cpu_reset_n;
  assign o_done        = r_done;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign o_error       = r_error;
`else
  assign o_error       = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (w_accept && w_is_hdr) begin
          w_next = S_COUNT;
        end else begin
          w_next = r_state;
        end
      end
      S_COUNT: begin
        if (w_accept) w_next = S_HI;
        else          w_next = r_state;
      end
      S_HI: begin
        if (w_accept) w_next = S_LO;
        else          w_next = r_state;
      end
      S_LO: begin
        if (w_accept) w_next = S_WRITE;
        else          w_next = r_state;
      end
      S_WRITE: begin
        if (r_words != 9'd1) begin
          w_next = S_HI;
        end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_next = S_CSUM;
`else
          w_next = S_DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (w_accept) begin
          w_next = (s_in.in_data == r_csum) ? S_DONE : S_ERR;
        end else begin
          w_next = r_state;
        end
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  // Registered outputs decode the upcoming state so they line up with it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_en       <= 1'b0;
      r_cpu_reset_n <= 1'b0;
      r_done        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_error       <= 1'b0;
`endif
    end else begin
      r_wr_en       <= (w_next == S_WRITE);
      r_cpu_reset_n <= (w_next == S_DONE);
      r_done        <= (w_next == S_DONE);
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_error       <= (w_next == S_ERR);
`endif
    end
  end

  // Word assembly, address/count bookkeeping and checksum accumulation
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_words   <= 9'd0;
      r_wr_addr <= 8'h00;
      r_wr_data <= 16'h0000;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum    <= 8'h00;
`endif
    end else begin
      case (r_state)
        S_COUNT: begin
          if (w_accept) begin
            // A count of zero encodes a full 256-word image
            r_words   <= (s_in.in_data == 8'h00) ? 9'd256 : {1'b0, s_in.in_data};
            r_wr_addr <= 8'h00;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum    <= 8'h00;
`endif
          end
        end
        S_HI: begin
          if (w_accept) begin
            r_wr_data[15:8] <= s_in.in_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum          <= r_csum + s_in.in_data;
`endif
          end
        end
        S_LO: begin
          if (w_accept) begin
            r_wr_data[7:0] <= s_in.in_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum         <= r_csum + s_in.in_data;
`endif
          end
        end
        S_WRITE: begin
          r_wr_addr <= r_wr_addr + 8'd1;
          r_words   <= r_words - 9'd1;
        end
        default: begin
          r_words <= r_words;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: expected writes are queued as bytes are driven
// and compared when the loader strobes wr_en.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        cpu_reset_n;
  logic        done;
  logic        error;

  imem_loader_if u_bus ();

  imem_loader dut (
    .clk           (clk),
    .reset         (reset),
    .s_in          (u_bus),
    .o_wr_en       (wr_en),
    .o_wr_addr     (wr_addr),
    .o_wr_data     (wr_data),
    .o_cpu_reset_n (cpu_reset_n),
    .o_done        (done),
    .o_error       (error)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          wr_count = 0;
  int          stall_cnt = 0;
  logic [7:0]  last_addr = 8'h00;
  logic [23:0] exp_q[$];
  logic [15:0] frame_words[$];
  logic [23:0] mon_e;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wr_count++;
      last_addr = wr_addr;
      if (exp_q.size() == 0) begin
        check_val("unexpected_wr", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_val("wr_addr", {24'd0, wr_addr}, {24'd0, mon_e[23:16]});
        check_val("wr_data", {16'd0, wr_data}, {16'd0, mon_e[15:0]});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    u_bus.in_data  = b;
    u_bus.in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      ok = u_bus.in_ready;
      if (!ok) stall_cnt++;
      @(posedge clk);
      if (ok) break;
      @(negedge clk);
    end
    if (!ok) check_val("send_timeout", 32'd0, 32'd1);
    #1 u_bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] n, input bit bad, input bit chk_hdr);
    logic [7:0] sum;
    logic [7:0] a;
    sum = 8'h00;
    send_byte(8'hA5);
    if (chk_hdr) begin
      check_val("hdr_cpu_reset_n", {31'd0, cpu_reset_n}, 32'd0);
      check_val("hdr_done", {31'd0, done}, 32'd0);
      check_val("hdr_error", {31'd0, error}, 32'd0);
    end
    send_byte(n);
    for (int i = 0; i < frame_words.size(); i++) begin
      a = i[7:0];
      exp_q.push_back({a, frame_words[i]});
      send_byte(frame_words[i][15:8]);
      send_byte(frame_words[i][7:0]);
      sum = sum + frame_words[i][15:8] + frame_words[i][7:0];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(bad ? sum + 8'd1 : sum);
`else
    if (bad) sum = 8'h00;
`endif
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_in_ready"}, {31'd0, u_bus.in_ready}, 32'd1);
    check_val({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
    check_val({tag, "_wr_addr"}, {24'd0, wr_addr}, 32'd0);
    check_val({tag, "_wr_data"}, {16'd0, wr_data}, 32'd0);
    check_val({tag, "_cpu_reset_n"}, {31'd0, cpu_reset_n}, 32'd0);
    check_val({tag, "_done"}, {31'd0, done}, 32'd0);
    check_val({tag, "_error"}, {31'd0, error}, 32'd0);
  endtask

  task automatic check_status(input string tag, input logic d, input logic e, input logic c);
    check_val({tag, "_done"}, {31'd0, done}, {31'd0, d});
    check_val({tag, "_error"}, {31'd0, error}, {31'd0, e});
    check_val({tag, "_cpu_reset_n"}, {31'd0, cpu_reset_n}, {31'd0, c});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset          = 1'b0;
    u_bus.in_valid = 1'b0;
    u_bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b1;

    // Noise before a header is discarded
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h11);
    repeat (3) @(negedge clk);
    check_val("noise_wr_count", wr_count, 32'd0);
    check_status("noise", 1'b0, 1'b0, 1'b0);

    // Three-word frame, streamed back to back so each WRITE stalls the next byte
    frame_words = '{16'h1234, 16'h5678, 16'h9ABC};
    stall_cnt = 0;
    send_frame(8'h03, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check_status("frameA", 1'b1, 1'b0, 1'b1);
    check_val("frameA_wr_count", wr_count, 32'd3);
    check_val("frameA_q_empty", exp_q.size(), 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check_val("frameA_stalls", stall_cnt, 32'd3);
`else
    check_val("frameA_stalls", stall_cnt, 32'd2);
`endif

    // Reload from DONE drops the core reset immediately after the header
    frame_words = '{16'hABCD};
    wr_count = 0;
    send_frame(8'h01, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check_status("reload", 1'b1, 1'b0, 1'b1);
    check_val("reload_wr_count", wr_count, 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Bad checksum: writes still happen, then error with the core held in reset
    frame_words = '{16'h1234, 16'h5678, 16'h9ABC};
    wr_count = 0;
    send_frame(8'h03, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check_status("badcsum", 1'b0, 1'b1, 1'b0);
    check_val("badcsum_wr_count", wr_count, 32'd3);
`endif

    // Count byte 0 loads a full 256-word image
    frame_words.delete();
    for (int i = 0; i < 256; i++) frame_words.push_back(16'($urandom));
    wr_count = 0;
    send_frame(8'h00, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check_status("full", 1'b1, 1'b0, 1'b1);
    check_val("full_wr_count", wr_count, 32'd256);
    check_val("full_last_addr", {24'd0, last_addr}, 32'hFF);

    // Reset after the high byte of word 1 abandons the load
    wr_count = 0;
    send_byte(8'hA5);
    send_byte(8'h02);
    exp_q.push_back({8'h00, 16'h1122});
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_vals("midrst");
    check_val("midrst_q_empty", exp_q.size(), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check_val("midrst_wr_count", wr_count, 32'd1);

    // Fresh frame after the abort starts again at address 0
    frame_words = '{16'hCAFE, 16'hBEEF};
    wr_count = 0;
    send_frame(8'h02, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check_status("fresh", 1'b1, 1'b0, 1'b1);
    check_val("fresh_wr_count", wr_count, 32'd2);
    check_val("fresh_q_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
